// File: rtl/rx_serial_param.sv
// Parameterised UART-style serial receiver: 2-flop input synchroniser, mid-bit
// sampling FSM, and a hand-shaked output word with parity/frame/overrun flags.
module rx_serial_param #(
  parameter int DATA_BITS    = 7,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 RX,
  input  logic                 recebe,
  output logic [DATA_BITS-1:0] dados,
  output logic                 pronto,
  output logic                 erro_paridade,
  output logic                 erro_frame,
  output logic                 overrun,
  output logic                 ocupado,
  output logic [2:0]           db_estado
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] START       = 3'd1;
  localparam logic [2:0] DATA        = 3'd2;
  localparam logic [2:0] PARIDADE    = 3'd3;
  localparam logic [2:0] STOP        = 3'd4;
  localparam logic [2:0] ENTREGA     = 3'd5;
  localparam logic [2:0] ESPERA_ALTO = 3'd6;

  logic [2:0]           state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic [CW-1:0]        cyc_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_err;
  logic                 frm_err;
  logic                 par_calc;

  // Synchroniser resets to the idle level so reset release never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_sync <= rx_meta;
    end
  end

  assign par_calc = (^shift_reg) ^ rx_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cyc_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_sync) begin
            state   <= START;
            par_err <= 1'b0;
            frm_err <= 1'b0;
          end
        end
        // Half-bit check rejects glitches and aligns later samples to mid-bit.
        START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        DATA: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt   <= '0;
            shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? PARIDADE : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        PARIDADE: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt <= '0;
            par_err <= (PARITY == 2) ? ~par_calc : par_calc;
            state   <= STOP;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        STOP: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt <= '0;
            if (!rx_sync) frm_err <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt <= '0;
              state   <= ENTREGA;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        // A line still low after the frame is a break; wait for idle so it yields one word.
        ENTREGA:     state <= rx_sync ? IDLE : ESPERA_ALTO;
        ESPERA_ALTO: if (rx_sync) state <= IDLE;
        default:     state <= IDLE;
      endcase
    end
  end

  // A new word always wins over an acknowledge arriving in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dados         <= '0;
      pronto        <= 1'b0;
      erro_paridade <= 1'b0;
      erro_frame    <= 1'b0;
      overrun       <= 1'b0;
    end else if (state == ENTREGA) begin
      dados         <= shift_reg;
      erro_paridade <= (PARITY != 0) && par_err;
      erro_frame    <= frm_err;
      pronto        <= 1'b1;
      overrun       <= pronto && !recebe;
    end else if (recebe && pronto) begin
      pronto  <= 1'b0;
      overrun <= 1'b0;
    end
  end

  assign ocupado   = (state != IDLE);
  assign db_estado = state;

endmodule

// File: doc/rx_serial_param.md
RX_SERIAL_PARAM -- requirements
Module: rx_serial_param

Interface
REQ-001 SHALL have parameter DATA_BITS, default 7, number of data bits per frame (legal 5..9).
REQ-002 SHALL have parameter PARITY, default 1, parity mode (0 none, 1 even, 2 odd).
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits checked (legal 1..2).
REQ-004 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per bit period (legal >= 4, even).
REQ-005 SHALL have port clock  input  1  system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-008 SHALL have port recebe  input  1  consumer acknowledge of current word.
REQ-009 SHALL have port dados  output  DATA_BITS  last received word, LSB = first data bit.
REQ-010 SHALL have port pronto  output  1  word available, held until acknowledged.
REQ-011 SHALL have port erro_paridade  output  1  parity error of word in dados (always 0 when PARITY=0).
REQ-012 SHALL have port erro_frame  output  1  stop-bit error of word in dados.
REQ-013 SHALL have port overrun  output  1  sticky: a word was overwritten while pronto was 1 and unacknowledged.
REQ-014 SHALL have port ocupado  output  1  high in every state except IDLE.
REQ-015 SHALL have port db_estado  output  3  current FSM state encoding.

Function
REQ-016 RX SHALL pass through a 2-flop synchronizer; all FSM decisions use the synchronized value (2-cycle input latency).
REQ-017 FSM states: IDLE(0), START(1), DATA(2), PARIDADE(3), STOP(4), ENTREGA(5), ESPERA_ALTO(6).
REQ-018 IDLE -> START on synchronized RX = 0; bit counter and cycle counter cleared on entry to START.
REQ-019 START: at CLKS_PER_BIT/2 cycles, RX = 0 -> DATA, RX = 1 -> IDLE (false start, no output change).
REQ-020 DATA: one sample every CLKS_PER_BIT cycles, shifted in LSB-first; after DATA_BITS samples -> PARIDADE if PARITY != 0, else STOP.
REQ-021 PARIDADE: one sample; error when (XOR of data bits XOR parity bit) != 0 for even, == 0 for odd.
REQ-022 STOP: STOP_BITS samples, one per bit period; any sample = 0 marks frame error; then -> ENTREGA.
REQ-023 ENTREGA lasts one cycle: dados, erro_paridade, erro_frame loaded together, pronto set to 1; -> IDLE if RX = 1, else -> ESPERA_ALTO.
REQ-024 ESPERA_ALTO -> IDLE only when synchronized RX = 1 (break condition produces exactly one word).
REQ-025 recebe = 1 while pronto = 1 SHALL clear pronto and overrun on the next edge; recebe while pronto = 0 SHALL have no effect.
REQ-026 ENTREGA while pronto = 1 and recebe = 0 SHALL overwrite dados/flags and set overrun.
REQ-027 ENTREGA and recebe in the same cycle: new word wins, pronto stays 1, overrun cleared and not set.
REQ-028 Frame-to-pronto latency: pronto rises at most 2 + CLKS_PER_BIT/2 cycles after the middle of the last stop bit, plus 1.
REQ-029 Cycle counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide; bit counter SHALL be 4 bits, no wrap within a frame.

Reset
REQ-030 reset = 0 SHALL immediately force state IDLE, dados = 0, pronto = 0, erro_paridade = 0, erro_frame = 0, overrun = 0, ocupado = 0, synchronizer flops = 1.
REQ-031 reset asserted mid-frame SHALL discard the partial word; after release the FSM waits for a new falling edge.

Verification (CLKS_PER_BIT = 16, defaults otherwise)
REQ-032 Send 'A' (0x41), even parity 0, 1 stop -> dados = 0x41, pronto = 1, both error flags 0; recebe pulse -> pronto = 0.
REQ-033 Send 0x41 with parity bit 1 -> dados = 0x41, erro_paridade = 1; repeat with PARITY = 2 -> erro_paridade = 0.
REQ-034 Send 0x55 with stop bit 0, RX held low 5 bit times -> erro_frame = 1, exactly one pronto, state 6 until RX high.
REQ-035 RX low pulse of 4 cycles -> no pronto, FSM returns to 0; two frames 0x11, 0x22 without recebe -> dados = 0x22, overrun = 1.
REQ-036 Assert reset during DATA of 0x7F -> all outputs 0 immediately; next frame 0x30 received correctly; DATA_BITS = 8, PARITY = 0, STOP_BITS = 2 with 0xA5 -> dados = 0xA5.
